// File: rtl/alu_issue_seq.sv
// alu_issue_seq
//   Multi-cycle fetch/decode/issue sequencer that sits between an instruction
//   memory and a purely combinational ALU. Each instruction walks through
//   FETCH -> DECODE -> EXEC -> WB. Operands come from an internal register
//   file. The ALU result is written back, or the PC is redirected when a
//   branch is taken.
//
//   Instruction word: [31:29] op, [28:24] rd, [23:19] rs, [18:14] rt,
//                     [13:0] imm (signed word offset)
//   Ops: 0 NOP, 1 HALT, 2 BEQ, 3 BLT, 4 ADD, 5 SUB, 6 AND, 7 OR
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             1-cycle pulse, begins execution at PC=0 from IDLE/HALT
//   imem_req/addr     fetch request and word address, held until imem_ack
//   imem_ack/rdata    fetch completion and instruction word
//   alu_ip_0/ip_1     registered ALU operands (reg[rs], reg[rt])
//   alu_opcode        registered ALU opcode (instruction op field)
//   alu_op_0          ALU result, sampled in EXEC
//   alu_change_pc     ALU branch-condition flag, sampled in EXEC
//   busy              high in FETCH/DECODE/EXEC/WB
//   halted            high in HALT
//   instr_done        1-cycle pulse in WB as each instruction retires
//   dbg_addr/dbg_data combinational register file read port (r0 reads 0)
//
// Handshake: imem_req is a strict valid. While it is high, imem_addr is
// stable. A cycle with imem_req=1 and imem_ack=1 completes the fetch, and
// imem_rdata is taken in that same cycle. imem_ack is ignored outside FETCH.
module alu_issue_seq #(
   parameter int PC_W     = 8,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     alu_ip_0,
   output logic [31:0]     alu_ip_1,
   output logic [2:0]      alu_opcode,
   input  logic [31:0]     alu_op_0,
   input  logic            alu_change_pc,
   output logic            busy,
   output logic            halted,
   output logic            instr_done,
   input  logic [4:0]      dbg_addr,
   output logic [31:0]     dbg_data
);

   // Register indices are 5 bits wide, so at most 32 registers are addressable.
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [2:0] OP_HALT = 3'd1;
   localparam logic [2:0] OP_BEQ  = 3'd2;
   localparam logic [2:0] OP_BLT  = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // state_q is the observable FSM state for checkers.
   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       ip0_q, ip0_d;
   logic [31:0]       ip1_q, ip1_d;
   logic [2:0]        opc_q, opc_d;
   logic [31:0]       res_q, res_d;
   logic              cpc_q, cpc_d;
   logic [31:0]       regs_q [NUM_REGS];
   logic [31:0]       regs_d [NUM_REGS];

   // Instruction fields
   logic [2:0]        op;
   logic [4:0]        rd, rs, rt;
   logic [PC_W-1:0]   imm_pc;
   logic [31:0]       rs_val, rt_val;
   logic              rd_ok;

   assign op = ir_q[31:29];
   assign rd = ir_q[28:24];
   assign rs = ir_q[23:19];
   assign rt = ir_q[18:14];
   // The size cast of a signed value sign-extends or truncates to PC_W.
   // The add then wraps naturally modulo 2**PC_W.
   assign imm_pc = PC_W'($signed(ir_q[13:0]));

   // Register reads. r0 and out-of-range indices read as zero.
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      dbg_data = '0;
      if (rs != 5'd0 && int'(rs) < NUM_REGS) rs_val = regs_q[rs[IDX_W-1:0]];
      if (rt != 5'd0 && int'(rt) < NUM_REGS) rt_val = regs_q[rt[IDX_W-1:0]];
      if (dbg_addr != 5'd0 && int'(dbg_addr) < NUM_REGS)
         dbg_data = regs_q[dbg_addr[IDX_W-1:0]];
   end

   assign rd_ok = (rd != 5'd0) && (int'(rd) < NUM_REGS);

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         ip0_q   <= '0;
         ip1_q   <= '0;
         opc_q   <= '0;
         res_q   <= '0;
         cpc_q   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ip0_q   <= ip0_d;
         ip1_q   <= ip1_d;
         opc_q   <= opc_d;
         res_q   <= res_d;
         cpc_q   <= cpc_d;
         regs_q  <= regs_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HALT: if (start) state_d = S_FETCH;
         S_FETCH:        if (imem_ack) state_d = S_DECODE;
         S_DECODE:       state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
         S_EXEC:         state_d = S_WB;
         S_WB:           state_d = S_FETCH;
         default:        state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      pc_d   = pc_q;
      ir_d   = ir_q;
      ip0_d  = ip0_q;
      ip1_d  = ip1_q;
      opc_d  = opc_q;
      res_d  = res_q;
      cpc_d  = cpc_q;
      regs_d = regs_q;
      case (state_q)
         S_IDLE, S_HALT: if (start) pc_d = '0;
         S_FETCH:        if (imem_ack) ir_d = imem_rdata;
         S_DECODE: begin
            // NOP is issued like any other opcode. Its result is never written.
            ip0_d = rs_val;
            ip1_d = rt_val;
            opc_d = op;
         end
         S_EXEC: begin
            res_d = alu_op_0;
            cpc_d = alu_change_pc;
         end
         S_WB: begin
            // Only branches look at change_pc. Every other op steps to PC+1.
            if ((op == OP_BEQ || op == OP_BLT) && cpc_q) pc_d = pc_q + imm_pc;
            else                                         pc_d = pc_q + PC_W'(1);
            // Ops 4-7 (top opcode bit set) write their result back to rd.
            if (op[2] && rd_ok) regs_d[rd[IDX_W-1:0]] = res_q;
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      imem_req   = (state_q == S_FETCH);
      imem_addr  = (state_q == S_FETCH) ? pc_q : '0;
      busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_WB);
      halted     = (state_q == S_HALT);
      instr_done = (state_q == S_WB);
   end

   assign alu_ip_0   = ip0_q;
   assign alu_ip_1   = ip1_q;
   assign alu_opcode = opc_q;

endmodule
